serial_add_n: RTL and testbench
===============================

// Module: serial_add_n
// PURPOSE
//  Parametrised multi-cycle adder, the next generation of the 1-bit full adder.
//  Adds two WIDTH-bit operands DIGIT bits per cycle, reusing one DIGIT-wide adder slice.
//  Sits between a requester and a consumer, with valid/ready handshakes on both sides.
//  Returns SUM, carry-out and signed overflow.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of DIGIT
//  DIGIT  4   bits added per cycle; STEPS = WIDTH/DIGIT cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operands A/B/C0 (and Sub) valid
//  in_ready   out  1      block can accept operands
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  C0         in   1      carry-in (borrow-in when subtracting)
//  Sub        in   1      1 = subtract; ignored unless ADD_SUB_EN is defined
//  out_valid  out  1      SUM/Carry/Overflow valid
//  out_ready  in   1      consumer takes the result
//  SUM        out  WIDTH  result
//  Carry      out  1      carry out of bit WIDTH-1
//  Overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-low.
//  - Reset (rst_n==0 at a rising edge), the only way back to IDLE outside the handshake:
//    - state=IDLE, step count=0, carry reg=0;
//    - in_ready=1, out_valid=0, SUM=0, Carry=0, Overflow=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid: latch A into opA and B into opB, set carry reg=C0, count=0, go to RUN.
//  - RUN, one step per cycle, in_ready=0:
//    - {c, s} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry reg, at DIGIT+1 bits.
//    - s shifts into SUM from the MSB side; opA and opB shift right by DIGIT.
//    - carry reg <= c.
//    - On the last step (count == STEPS-1):
//      - record the carry into bit WIDTH-1 from the last slice;
//      - Carry = c; Overflow = carry_into_msb ^ c;
//      - go to DONE.
//  - Latency: operands accepted at edge k give out_valid=1 after edge k+STEPS.
//    For the defaults that is 8 cycles.
//  - DONE:
//    - out_valid=1 and in_ready=0; SUM/Carry/Overflow held stable.
//    - Stays in DONE for as long as out_ready=0.
//    - When out_valid && out_ready: go to IDLE next cycle.
//    - No back-to-back accept; in_ready rises one cycle after the output handshake.
//  - SUM/Carry/Overflow keep their last value in IDLE and RUN.
//    They are meaningful only while out_valid=1.
//  - in_valid while in RUN/DONE is ignored; the requester holds it until in_ready.
//  - Arithmetic is modulo 2^WIDTH. A wraparound shows as Carry=1, not as an error.
//  - Reset mid-RUN or mid-DONE aborts with no output and applies the reset values above.
// CONFIGURATION
//  - ADD_SUB_EN defined:
//    - Sub is sampled with the operands in IDLE.
//    - If Sub=1, opB latches ~B and carry reg latches ~C0, so SUM = A - B - C0.
//    - Carry=1 means no borrow; Overflow is the signed subtract overflow.
//  - ADD_SUB_EN undefined:
//    - Sub is unused and the block only adds.
//    - No inverter logic is generated.
// TESTING
//  - T1: A=32'h0000_0001, B=32'hFFFF_FFFF, C0=0 -> SUM=0, Carry=1, Overflow=0.
//    out_valid rises exactly 8 cycles after the accept.
//  - T2: A=32'h7FFF_FFFF, B=1, C0=0 -> SUM=32'h8000_0000, Carry=0, Overflow=1.
//  - T3: hold out_ready=0 for 5 cycles in DONE.
//    -> out_valid=1, SUM stable, in_ready=0 throughout;
//    -> on out_ready=1, in_ready=1 the next cycle.
//  - T4: rst_n=0 at RUN step 3 -> next cycle in_ready=1, out_valid=0, SUM=0, no result emitted.
//  - T5 (ADD_SUB_EN): Sub=1, A=5, B=7, C0=0 -> SUM=32'hFFFF_FFFE, Carry=0, Overflow=0.
//    Then A=32'h8000_0000, B=1 -> SUM=32'h7FFF_FFFF, Overflow=1.
//  - T6: WIDTH=8, DIGIT=1, A=8'hFF, B=8'h01, C0=1 -> SUM=8'h01, Carry=1, Overflow=0.
//    Latency is 8 cycles.

Source files
------------

// File: rtl/serial_add_n_if.sv
// serial_add_n_if: handshake bundle for the serial_add_n multi-cycle adder.
//   in_valid / in_ready   : operand handshake (requester -> adder)
//   A, B, C0, Sub         : operands, carry/borrow-in, subtract select
//   out_valid / out_ready : result handshake (adder -> consumer)
//   SUM, Carry, Overflow  : result, carry out of MSB, signed overflow
// Modports: master = requester/consumer side, slave = adder side.
interface serial_add_n_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             Carry;
  logic             Overflow;

  modport master (
    output in_valid, A, B, C0, Sub, out_ready,
    input  in_ready, out_valid, SUM, Carry, Overflow
  );

  modport slave (
    input  in_valid, A, B, C0, Sub, out_ready,
    output in_ready, out_valid, SUM, Carry, Overflow
  );
endinterface

// File: rtl/serial_add_n.sv
// serial_add_n: multi-cycle adder adding two WIDTH-bit operands DIGIT bits per
// clock through a single DIGIT-wide adder slice (WIDTH/DIGIT cycles per op).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_add_n_if.slave (operand and result valid/ready handshakes,
//           A/B/C0/Sub in, SUM/Carry/Overflow out)
// Parameters: WIDTH (multiple of DIGIT), DIGIT.
// Optional feature macro: ADD_SUB_EN -- when defined, Sub=1 makes the block
// compute A - B - C0 (B and C0 inverted at capture). Undefined: add only.
module serial_add_n #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  serial_add_n_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW    = DIGIT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             carry_o_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] b_in_d;
  logic             c_in_d;

`ifdef ADD_SUB_EN
  // Subtraction as A + ~B + ~C0: a borrow-in of 1 becomes a carry-in of 0.
  assign b_in_d = bus.Sub ? ~bus.B  : bus.B;
  assign c_in_d = bus.Sub ? ~bus.C0 : bus.C0;
`else
  logic unused_sub;
  assign b_in_d     = bus.B;
  assign c_in_d     = bus.C0;
  assign unused_sub = bus.Sub;
`endif

  // The one shared adder slice, working on the low digit of the shifting operands.
  logic [DIGIT:0]         slice_d;
  logic                   msb_cin_d;
  logic [WIDTH+DIGIT-1:0] acc_cat_d;
  logic [WIDTH-1:0]       acc_d;

  assign slice_d   = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + SW'(carry_q);
  // Carry into the slice's top bit recovered from sum ^ a ^ b at that bit;
  // on the last step this is the carry into bit WIDTH-1.
  assign msb_cin_d = slice_d[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
  // New digit enters from the MSB side; after STEPS shifts the result is aligned.
  assign acc_cat_d = {slice_d[DIGIT-1:0], acc_q};
  assign acc_d     = acc_cat_d[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_o_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opa_q      <= bus.A;
            opb_q      <= b_in_d;
            carry_q    <= c_in_d;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          carry_q <= slice_d[DIGIT];
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          // Results are published only at the end so SUM stays put during RUN.
          if (cnt_q == LAST) begin
            sum_q       <= acc_d;
            carry_o_q   <= slice_d[DIGIT];
            ovf_q       <= msb_cin_d ^ slice_d[DIGIT];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.SUM       = sum_q;
  assign bus.Carry     = carry_o_q;
  assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_n.sv
// tb_serial_add_n: randomized self-checking bench for serial_add_n.
// Two instances: 32-bit/4-bit digits and 8-bit/1-bit digits. A plain-arithmetic
// reference model gives the expected SUM/Carry/Overflow. Honors ADD_SUB_EN.
module tb_serial_add_n;
  localparam int W0 = 32;
  localparam int D0 = 4;
  localparam int W1 = 8;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_n_if #(.WIDTH(W0)) b32 ();
  serial_add_n_if #(.WIDTH(W1)) b8 ();

  serial_add_n #(.WIDTH(W0), .DIGIT(D0)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  serial_add_n #(.WIDTH(W1), .DIGIT(D1)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  // Shared stimulus, steered to one instance by sel (0 = 32-bit, 1 = 8-bit).
  logic        sel;
  logic        in_valid_t, out_ready_t, c0_t, sub_t;
  logic [31:0] a_t, b_t;

  assign b32.in_valid  = in_valid_t & ~sel;
  assign b8.in_valid   = in_valid_t & sel;
  assign b32.out_ready = out_ready_t & ~sel;
  assign b8.out_ready  = out_ready_t & sel;
  assign b32.A   = a_t;
  assign b32.B   = b_t;
  assign b8.A    = a_t[7:0];
  assign b8.B    = b_t[7:0];
  assign b32.C0  = c0_t;
  assign b8.C0   = c0_t;
  assign b32.Sub = sub_t;
  assign b8.Sub  = sub_t;

  logic        rdy_o, vld_o, cy_o, ov_o;
  logic [31:0] sum_o;
  assign rdy_o = sel ? b8.in_ready  : b32.in_ready;
  assign vld_o = sel ? b8.out_valid : b32.out_valid;
  assign cy_o  = sel ? b8.Carry     : b32.Carry;
  assign ov_o  = sel ? b8.Overflow  : b32.Overflow;
  assign sum_o = sel ? {24'h0, b8.SUM} : b32.SUM;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit add (or subtract as A + ~B + ~C0) done in 64-bit arithmetic.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic c0, input logic s,
                       output logic [31:0] sum, output logic cy, output logic ov);
    logic [63:0] mask, aa, bb, full;
    logic        cc;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = s ? (~{32'h0, b}) & mask : {32'h0, b} & mask;
    cc   = s ? ~c0 : c0;
    full = aa + bb + {63'h0, cc};
    sum  = 32'(full & mask);
    cy   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c0, input logic s, input int hold);
    int          w, steps, cyc, lat;
    logic        s_eff, ecy, eov;
    logic [31:0] esum;
    w     = sel ? W1 : W0;
    steps = sel ? W1 / D1 : W0 / D0;
`ifdef ADD_SUB_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    model(w, a, b, c0, s_eff, esum, ecy, eov);
    cyc = 0;
    while (!rdy_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_in_ready"}, rdy_o, 1);
    a_t = a; b_t = b; c0_t = c0; sub_t = s;
    in_valid_t = 1'b1;
    @(negedge clk);
    in_valid_t = 1'b0;
    a_t = $urandom; b_t = $urandom; c0_t = $urandom; sub_t = $urandom;
    check({tag, "_busy"}, rdy_o, 0);
    lat = 0;
    while (!vld_o && lat < 4 * steps) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, steps);
    check({tag, "_sum"}, sum_o, esum);
    check({tag, "_carry"}, cy_o, ecy);
    check({tag, "_ovf"}, ov_o, eov);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, vld_o, 1);
      check({tag, "_hold_sum"}, sum_o, esum);
      check({tag, "_hold_rdy"}, rdy_o, 0);
    end
    out_ready_t = 1'b1;
    @(negedge clk);
    out_ready_t = 1'b0;
    check({tag, "_vld_drop"}, vld_o, 0);
    check({tag, "_rdy_back"}, rdy_o, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; in_valid_t = 1'b0; out_ready_t = 1'b0;
    a_t = '0; b_t = '0; c0_t = 1'b0; sub_t = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst32_rdy", b32.in_ready, 1);
    check("rst32_vld", b32.out_valid, 0);
    check("rst32_sum", b32.SUM, 0);
    check("rst32_cy", b32.Carry, 0);
    check("rst32_ov", b32.Overflow, 0);
    check("rst8_rdy", b8.in_ready, 1);
    check("rst8_vld", b8.out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the 32-bit instance.
    run_op("t1", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op("t2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("t3", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 5);
`ifdef ADD_SUB_EN
    run_op("t5a", 32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op("t5b", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1);
`endif

    // Reset during RUN step 3 aborts the operation.
    a_t = 32'hDEAD_BEEF; b_t = 32'h0101_0101; c0_t = 1'b1; sub_t = 1'b0;
    in_valid_t = 1'b1;
    @(negedge clk);
    in_valid_t = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_rdy", rdy_o, 1);
    check("t4_vld", vld_o, 0);
    check("t4_sum", sum_o, 0);
    for (int i = 0; i < (W0 / D0) + 2; i++) begin
      @(negedge clk);
      check("t4_no_out", vld_o, 0);
    end

    for (int i = 0; i < 20; i++)
      run_op("rnd32", $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    run_op("edge32", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    run_op("edge32z", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);

    // 8-bit, one bit per cycle.
    sel = 1'b1;
    @(negedge clk);
    run_op("t6", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++)
      run_op("rnd8", $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
